// File: rtl/morse_line_decoder.sv
// Morse line decoder: times marks/spaces on a relay line and assembles dot/dash characters.
// Optional `MORSE_ASCII_EN adds a registered sym_ascii output (A-Z, 0-9, else '?').
module morse_line_decoder #(
   parameter int DOT_TICKS = 4,
   parameter int MAX_ELEMS = 5
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 line,
   output logic                 sym_valid,
   output logic [2:0]           sym_len,
   output logic [MAX_ELEMS-1:0] sym_bits,
   output logic                 err
`ifdef MORSE_ASCII_EN
   ,
   output logic [7:0]           sym_ascii
`endif
);

   localparam int CW = $clog2(3*DOT_TICKS + 1);
   localparam logic [CW-1:0] CNT_MAX  = CW'(3*DOT_TICKS);
   localparam logic [CW-1:0] CNT_LAST = CW'(3*DOT_TICKS - 1);
   localparam logic [CW-1:0] CNT_DASH = CW'(2*DOT_TICKS);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [2:0]    LEN_MAX  = 3'(MAX_ELEMS);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] MARK  = 2'd1;
   localparam logic [1:0] SPACE = 2'd2;
   localparam logic [1:0] DROP  = 2'd3;

   logic [1:0]           state;
   logic [CW-1:0]        cnt;
   logic [2:0]           len;
   logic [MAX_ELEMS-1:0] elems;
   logic                 prev_line;
   logic                 is_dash;

   assign is_dash = (cnt >= CNT_DASH);

`ifdef MORSE_ASCII_EN
   function automatic logic [7:0] ascii_of(input logic [2:0] n, input logic [MAX_ELEMS-1:0] code);
      logic [4:0] c;
      c = '0;
      for (int unsigned i = 0; i < 5; i++)
         if (i < MAX_ELEMS) c[i] = code[i];
      // code bit 0 is the first element; 1 = dash
      case ({n, c})
         {3'd2, 5'b00010}: ascii_of = 8'h41; // A
         {3'd4, 5'b00001}: ascii_of = 8'h42; // B
         {3'd4, 5'b00101}: ascii_of = 8'h43; // C
         {3'd3, 5'b00001}: ascii_of = 8'h44; // D
         {3'd1, 5'b00000}: ascii_of = 8'h45; // E
         {3'd4, 5'b00100}: ascii_of = 8'h46; // F
         {3'd3, 5'b00011}: ascii_of = 8'h47; // G
         {3'd4, 5'b00000}: ascii_of = 8'h48; // H
         {3'd2, 5'b00000}: ascii_of = 8'h49; // I
         {3'd4, 5'b01110}: ascii_of = 8'h4A; // J
         {3'd3, 5'b00101}: ascii_of = 8'h4B; // K
         {3'd4, 5'b00010}: ascii_of = 8'h4C; // L
         {3'd2, 5'b00011}: ascii_of = 8'h4D; // M
         {3'd2, 5'b00001}: ascii_of = 8'h4E; // N
         {3'd3, 5'b00111}: ascii_of = 8'h4F; // O
         {3'd4, 5'b00110}: ascii_of = 8'h50; // P
         {3'd4, 5'b01011}: ascii_of = 8'h51; // Q
         {3'd3, 5'b00010}: ascii_of = 8'h52; // R
         {3'd3, 5'b00000}: ascii_of = 8'h53; // S
         {3'd1, 5'b00001}: ascii_of = 8'h54; // T
         {3'd3, 5'b00100}: ascii_of = 8'h55; // U
         {3'd4, 5'b01000}: ascii_of = 8'h56; // V
         {3'd3, 5'b00110}: ascii_of = 8'h57; // W
         {3'd4, 5'b01001}: ascii_of = 8'h58; // X
         {3'd4, 5'b01101}: ascii_of = 8'h59; // Y
         {3'd4, 5'b00011}: ascii_of = 8'h5A; // Z
         {3'd5, 5'b11111}: ascii_of = 8'h30;
         {3'd5, 5'b11110}: ascii_of = 8'h31;
         {3'd5, 5'b11100}: ascii_of = 8'h32;
         {3'd5, 5'b11000}: ascii_of = 8'h33;
         {3'd5, 5'b10000}: ascii_of = 8'h34;
         {3'd5, 5'b00000}: ascii_of = 8'h35;
         {3'd5, 5'b00001}: ascii_of = 8'h36;
         {3'd5, 5'b00011}: ascii_of = 8'h37;
         {3'd5, 5'b00111}: ascii_of = 8'h38;
         {3'd5, 5'b01111}: ascii_of = 8'h39;
         default:          ascii_of = 8'h3F;
      endcase
   endfunction
`endif

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state     <= IDLE;
         cnt       <= '0;
         len       <= '0;
         elems     <= '0;
         prev_line <= 1'b1;
         sym_valid <= 1'b0;
         err       <= 1'b0;
         sym_len   <= '0;
         sym_bits  <= '0;
`ifdef MORSE_ASCII_EN
         sym_ascii <= '0;
`endif
      end else begin
         prev_line <= line;
         sym_valid <= 1'b0;
         err       <= 1'b0;
         case (state)
            IDLE: begin
               if (line && !prev_line) begin
                  state <= MARK;
                  cnt   <= CNT_ONE;
               end
            end
            MARK: begin
               if (line) begin
                  if (cnt != CNT_MAX) cnt <= cnt + CNT_ONE;
               end else if (len < LEN_MAX) begin
                  elems <= elems | (MAX_ELEMS'(is_dash) << len);
                  len   <= len + 3'd1;
                  state <= SPACE;
                  cnt   <= CNT_ONE;
               end else begin
                  err   <= 1'b1;
                  state <= DROP;
                  cnt   <= CNT_ONE;
               end
            end
            SPACE: begin
               if (line) begin
                  state <= MARK;
                  cnt   <= CNT_ONE;
               end else if (cnt == CNT_LAST) begin
                  // this edge takes the final low sample of the letter gap
                  sym_valid <= 1'b1;
                  sym_len   <= len;
                  sym_bits  <= elems;
`ifdef MORSE_ASCII_EN
                  sym_ascii <= ascii_of(len, elems);
`endif
                  elems <= '0;
                  len   <= '0;
                  cnt   <= '0;
                  state <= IDLE;
               end else begin
                  cnt <= cnt + CNT_ONE;
               end
            end
            default: begin
               if (line) begin
                  cnt <= '0;
               end else if (cnt >= CNT_LAST) begin
                  elems <= '0;
                  len   <= '0;
                  cnt   <= '0;
                  state <= IDLE;
               end else begin
                  cnt <= cnt + CNT_ONE;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_morse_line_decoder.sv
// Directed bench for morse_line_decoder (DOT_TICKS=4, MAX_ELEMS=5).
module tb_morse_line_decoder;

   logic       clk;
   logic       reset_n;
   logic       line;
   logic       sym_valid;
   logic [2:0] sym_len;
   logic [4:0] sym_bits;
   logic       err;
`ifdef MORSE_ASCII_EN
   logic [7:0] sym_ascii;
`endif

   int checks = 0;
   int errors = 0;
   int nvalid = 0;
   int nerr   = 0;
   int nboth  = 0;

   morse_line_decoder #(.DOT_TICKS(4), .MAX_ELEMS(5)) dut (
      .clk(clk),
      .reset_n(reset_n),
      .line(line),
      .sym_valid(sym_valid),
      .sym_len(sym_len),
      .sym_bits(sym_bits),
      .err(err)
`ifdef MORSE_ASCII_EN
      ,
      .sym_ascii(sym_ascii)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (sym_valid === 1'b1) nvalid++;
      if (err === 1'b1) nerr++;
      if (sym_valid === 1'b1 && err === 1'b1) nboth++;
   end

   task automatic drive(input logic v, input int n);
      repeat (n) begin
         line = v;
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      drive(1'b0, 3);
      checks++;
      if (sym_valid !== 1'b0 || err !== 1'b0) begin
         errors++;
         $display("FAIL reset_strobes: valid=%b err=%b required 0 0", sym_valid, err);
      end
      checks++;
      if (sym_len !== 3'd0 || sym_bits !== 5'd0) begin
         errors++;
         $display("FAIL reset_outputs: len=%0d bits=%b required 0 00000", sym_len, sym_bits);
      end
      reset_n = 1'b1;
      drive(1'b0, 2);
   endtask

   task automatic test_letter_a();
      int v0;
      v0 = nvalid;
      drive(1'b1, 4);
      drive(1'b0, 4);
      drive(1'b1, 12);
      drive(1'b0, 11);
      checks++;
      if (sym_valid !== 1'b0) begin
         errors++;
         $display("FAIL a_early: valid=%b required 0", sym_valid);
      end
      drive(1'b0, 1);
      checks++;
      if (sym_valid !== 1'b1 || sym_len !== 3'd2 || sym_bits !== 5'b00010) begin
         errors++;
         $display("FAIL a_char: valid=%b len=%0d bits=%b required 1 2 00010", sym_valid, sym_len, sym_bits);
      end
`ifdef MORSE_ASCII_EN
      checks++;
      if (sym_ascii !== 8'h41) begin
         errors++;
         $display("FAIL a_ascii: got %h required 41", sym_ascii);
      end
`endif
      drive(1'b0, 6);
      checks++;
      if (sym_valid !== 1'b0 || nvalid - v0 !== 1) begin
         errors++;
         $display("FAIL a_single_pulse: valid=%b pulses=%0d required 0 1", sym_valid, nvalid - v0);
      end
      checks++;
      if (sym_len !== 3'd2 || sym_bits !== 5'b00010) begin
         errors++;
         $display("FAIL a_hold: len=%0d bits=%b required 2 00010", sym_len, sym_bits);
      end
   endtask

   task automatic test_threshold();
      drive(1'b1, 7);
      drive(1'b0, 12);
      checks++;
      if (sym_valid !== 1'b1 || sym_len !== 3'd1 || sym_bits !== 5'b00000) begin
         errors++;
         $display("FAIL thr_dot7: valid=%b len=%0d bits=%b required 1 1 00000", sym_valid, sym_len, sym_bits);
      end
      drive(1'b0, 2);
      drive(1'b1, 8);
      drive(1'b0, 12);
      checks++;
      if (sym_valid !== 1'b1 || sym_len !== 3'd1 || sym_bits !== 5'b00001) begin
         errors++;
         $display("FAIL thr_dash8: valid=%b len=%0d bits=%b required 1 1 00001", sym_valid, sym_len, sym_bits);
      end
      drive(1'b0, 2);
      drive(1'b1, 40);
      drive(1'b0, 12);
      checks++;
      if (sym_valid !== 1'b1 || sym_len !== 3'd1 || sym_bits !== 5'b00001) begin
         errors++;
         $display("FAIL thr_saturate: valid=%b len=%0d bits=%b required 1 1 00001", sym_valid, sym_len, sym_bits);
      end
      drive(1'b0, 2);
   endtask

   task automatic test_gap_boundary();
      int v0;
      v0 = nvalid;
      drive(1'b1, 4);
      drive(1'b0, 11);
      checks++;
      if (sym_valid !== 1'b0) begin
         errors++;
         $display("FAIL gap11_nosplit: valid=%b required 0", sym_valid);
      end
      drive(1'b1, 4);
      drive(1'b0, 12);
      checks++;
      if (sym_valid !== 1'b1 || sym_len !== 3'd2 || sym_bits !== 5'b00000) begin
         errors++;
         $display("FAIL gap11_char: valid=%b len=%0d bits=%b required 1 2 00000", sym_valid, sym_len, sym_bits);
      end
      drive(1'b0, 2);
      checks++;
      if (nvalid - v0 !== 1) begin
         errors++;
         $display("FAIL gap11_pulses: got %0d required 1", nvalid - v0);
      end
      v0 = nvalid;
      drive(1'b1, 4);
      drive(1'b0, 12);
      checks++;
      if (sym_valid !== 1'b1 || sym_len !== 3'd1) begin
         errors++;
         $display("FAIL gap12_first: valid=%b len=%0d required 1 1", sym_valid, sym_len);
      end
      drive(1'b1, 4);
      drive(1'b0, 12);
      checks++;
      if (sym_valid !== 1'b1 || sym_len !== 3'd1) begin
         errors++;
         $display("FAIL gap12_second: valid=%b len=%0d required 1 1", sym_valid, sym_len);
      end
      drive(1'b0, 2);
      checks++;
      if (nvalid - v0 !== 2) begin
         errors++;
         $display("FAIL gap12_pulses: got %0d required 2", nvalid - v0);
      end
   endtask

   task automatic test_overflow();
      int v0;
      int e0;
      v0 = nvalid;
      e0 = nerr;
      for (int k = 0; k < 6; k++) begin
         drive(1'b1, 4);
         if (k < 5) drive(1'b0, 4);
      end
      checks++;
      if (err !== 1'b0) begin
         errors++;
         $display("FAIL ovf_err_early: err=%b required 0", err);
      end
      drive(1'b0, 1);
      checks++;
      if (err !== 1'b1) begin
         errors++;
         $display("FAIL ovf_err_pulse: err=%b required 1", err);
      end
      drive(1'b0, 1);
      checks++;
      if (err !== 1'b0) begin
         errors++;
         $display("FAIL ovf_err_width: err=%b required 0", err);
      end
      drive(1'b0, 12);
      checks++;
      if (nvalid - v0 !== 0 || nerr - e0 !== 1) begin
         errors++;
         $display("FAIL ovf_counts: valid_pulses=%0d err_pulses=%0d required 0 1", nvalid - v0, nerr - e0);
      end
      drive(1'b1, 4);
      drive(1'b0, 12);
      checks++;
      if (sym_valid !== 1'b1 || sym_len !== 3'd1 || sym_bits !== 5'b00000) begin
         errors++;
         $display("FAIL ovf_then_e: valid=%b len=%0d bits=%b required 1 1 00000", sym_valid, sym_len, sym_bits);
      end
      drive(1'b0, 2);
   endtask

   task automatic test_reset_mid_char();
      int v0;
      int e0;
      drive(1'b1, 4);
      drive(1'b0, 4);
      drive(1'b1, 4);
      drive(1'b0, 2);
      v0 = nvalid;
      e0 = nerr;
      reset_n = 1'b0;
      drive(1'b1, 1);
      reset_n = 1'b1;
      checks++;
      if (sym_len !== 3'd0 || sym_bits !== 5'd0 || sym_valid !== 1'b0) begin
         errors++;
         $display("FAIL rst_mid_clear: len=%0d bits=%b valid=%b required 0 00000 0", sym_len, sym_bits, sym_valid);
      end
      drive(1'b1, 10);
      drive(1'b0, 12);
      drive(1'b0, 2);
      checks++;
      if (nvalid - v0 !== 0 || nerr - e0 !== 0) begin
         errors++;
         $display("FAIL rst_mid_quiet: valid_pulses=%0d err_pulses=%0d required 0 0", nvalid - v0, nerr - e0);
      end
      drive(1'b1, 4);
      drive(1'b0, 12);
      checks++;
      if (sym_valid !== 1'b1 || sym_len !== 3'd1 || sym_bits !== 5'b00000) begin
         errors++;
         $display("FAIL rst_mid_next: valid=%b len=%0d bits=%b required 1 1 00000", sym_valid, sym_len, sym_bits);
      end
      drive(1'b0, 2);
   endtask

   task automatic test_back_to_back();
      int e0;
      e0 = nerr;
      for (int k = 0; k < 5; k++) begin
         drive(1'b1, 12);
         drive(1'b0, (k < 4) ? 4 : 12);
      end
      checks++;
      if (sym_valid !== 1'b1 || sym_len !== 3'd5 || sym_bits !== 5'b11111 || nerr !== e0) begin
         errors++;
         $display("FAIL five_dash: valid=%b len=%0d bits=%b errs=%0d required 1 5 11111 0", sym_valid, sym_len, sym_bits, nerr - e0);
      end
`ifdef MORSE_ASCII_EN
      checks++;
      if (sym_ascii !== 8'h30) begin
         errors++;
         $display("FAIL five_dash_ascii: got %h required 30", sym_ascii);
      end
`endif
      drive(1'b1, 4);
      drive(1'b0, 4);
      drive(1'b1, 4);
      drive(1'b0, 4);
      drive(1'b1, 12);
      drive(1'b0, 4);
      drive(1'b1, 12);
      drive(1'b0, 12);
      checks++;
      if (sym_valid !== 1'b1 || sym_len !== 3'd4 || sym_bits !== 5'b01100) begin
         errors++;
         $display("FAIL ddaa: valid=%b len=%0d bits=%b required 1 4 01100", sym_valid, sym_len, sym_bits);
      end
`ifdef MORSE_ASCII_EN
      checks++;
      if (sym_ascii !== 8'h3F) begin
         errors++;
         $display("FAIL ddaa_ascii: got %h required 3f", sym_ascii);
      end
`endif
      drive(1'b0, 2);
      checks++;
      if (nboth !== 0) begin
         errors++;
         $display("FAIL valid_err_overlap: got %0d cycles required 0", nboth);
      end
   endtask

   initial begin
      line    = 1'b0;
      reset_n = 1'b0;
      test_reset();
      test_letter_a();
      test_threshold();
      test_gap_boundary();
      test_overflow();
      test_reset_mid_char();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
